icw_ocw_sequencer: RTL and testbench

Sequential command-word engine for the PIC: samples CPU writes from the bus-interface stage (write strobe, chip select, A0, internal data bus) and drives the ICW initialization sequence state machine. Holds every ICW/OCW-derived control field as registers. Issues one-cycle OCW2/OCW3 command pulses to the priority resolver, interrupt mask and cascade logic downstream.

---
 rtl/icw_ocw_sequencer.sv | 154 +++++++++++++++
 tb/tb_icw_ocw_sequencer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/icw_ocw_sequencer.sv
// icw_ocw_sequencer: captures CPU command-word writes, walks the ICW1..ICW4
// initialization sequence and holds all ICW/OCW control fields. Once the
// sequence completes it turns OCW2/OCW3 writes into one-cycle command pulses.
// Optional feature macro: PIC_POLL_EN (OCW3 P bit raises poll_pulse).
module icw_ocw_sequencer (
  input  logic       clk,
  input  logic       reset,
  input  logic       write_bar,
  input  logic       chip_select_bar,
  input  logic       A0,
  input  logic [7:0] internal_bus,
  output logic       init_done,
  output logic [4:0] vector_base,
  output logic       ltim,
  output logic       single_mode,
  output logic [7:0] cascade_cfg,
  output logic [4:0] icw4_cfg,
  output logic [7:0] imr,
  output logic       ocw2_valid,
  output logic [2:0] ocw2_cmd,
  output logic [2:0] ocw2_level,
  output logic       read_isr_sel,
  output logic       special_mask,
  output logic       poll_pulse,
  output logic       seq_error
);

  typedef enum logic [2:0] {S_UNINIT, S_ICW2, S_ICW3, S_ICW4, S_READY} state_t;

  state_t     state, state_nxt;
  logic       wr_act, wr_act_q, commit;
  logic [7:0] data_q;
  logic       a0_q, ic4;
  logic       is_icw1, ld_icw2, ld_icw3, ld_icw4, ld_ocw1, do_ocw2, do_ocw3, err;

  // Either strobe going inactive ends the write; decode on the trailing edge.
  assign wr_act = ~write_bar & ~chip_select_bar;
  assign commit = ~wr_act & wr_act_q;

  // Write capture: data/address follow the bus only while the write is active.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_act_q <= 1'b0;
      data_q   <= 8'h00;
      a0_q     <= 1'b0;
    end else begin
      wr_act_q <= wr_act;
      if (wr_act) begin
        data_q <= internal_bus;
        a0_q   <= A0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_UNINIT;
    else       state <= state_nxt;
  end

  // Next-state and command decode of the committed write.
  always_comb begin
    state_nxt = state;
    is_icw1   = 1'b0;
    ld_icw2   = 1'b0;
    ld_icw3   = 1'b0;
    ld_icw4   = 1'b0;
    ld_ocw1   = 1'b0;
    do_ocw2   = 1'b0;
    do_ocw3   = 1'b0;
    err       = 1'b0;
    if (commit) begin
      if (!a0_q && data_q[4]) begin
        is_icw1   = 1'b1;
        state_nxt = S_ICW2;
      end else begin
        case (state)
          S_ICW2: if (a0_q) begin
                    ld_icw2   = 1'b1;
                    state_nxt = !single_mode ? S_ICW3 : (ic4 ? S_ICW4 : S_READY);
                  end else err = 1'b1;
          S_ICW3: if (a0_q) begin
                    ld_icw3   = 1'b1;
                    state_nxt = ic4 ? S_ICW4 : S_READY;
                  end else err = 1'b1;
          S_ICW4: if (a0_q) begin
                    ld_icw4   = 1'b1;
                    state_nxt = S_READY;
                  end else err = 1'b1;
          S_READY: if (a0_q)          ld_ocw1 = 1'b1;
                   else if (!data_q[3]) do_ocw2 = 1'b1;
                   else                 do_ocw3 = 1'b1;
          default: ;  // S_UNINIT ignores everything but ICW1
        endcase
      end
    end
  end

  // Control field registers and one-cycle command pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      init_done    <= 1'b0;
      vector_base  <= 5'h00;
      ltim         <= 1'b0;
      single_mode  <= 1'b0;
      ic4          <= 1'b0;
      cascade_cfg  <= 8'h00;
      icw4_cfg     <= 5'h00;
      imr          <= 8'h00;
      ocw2_valid   <= 1'b0;
      ocw2_cmd     <= 3'b000;
      ocw2_level   <= 3'b000;
      read_isr_sel <= 1'b0;
      special_mask <= 1'b0;
      seq_error    <= 1'b0;
    end else begin
      ocw2_valid <= do_ocw2;
      seq_error  <= err;
      if (is_icw1) begin
        ltim         <= data_q[3];
        single_mode  <= data_q[1];
        ic4          <= data_q[0];
        imr          <= 8'h00;
        icw4_cfg     <= 5'h00;
        special_mask <= 1'b0;
        read_isr_sel <= 1'b0;
        init_done    <= 1'b0;
      end else if (state_nxt == S_READY && state != S_READY) begin
        init_done <= 1'b1;
      end
      if (ld_icw2) vector_base <= data_q[7:3];
      if (ld_icw3) cascade_cfg <= data_q;
      if (ld_icw4) icw4_cfg    <= data_q[4:0];
      if (ld_ocw1) imr         <= data_q;
      if (do_ocw2) begin
        ocw2_cmd   <= data_q[7:5];
        ocw2_level <= data_q[2:0];
      end
      if (do_ocw3 && data_q[1]) read_isr_sel <= data_q[0];
      if (do_ocw3 && data_q[6]) special_mask <= data_q[5];
    end
  end

`ifdef PIC_POLL_EN
  // Poll command pulse from the OCW3 P bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) poll_pulse <= 1'b0;
    else       poll_pulse <= do_ocw3 & data_q[2];
  end
`else
  assign poll_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_icw_ocw_sequencer.sv
// Directed bench for icw_ocw_sequencer: ICW sequences, OCW commands,
// sequence errors, chip-select-terminated writes and async reset mid-write.
module tb_icw_ocw_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       write_bar = 1'b1;
  logic       chip_select_bar = 1'b1;
  logic       A0 = 1'b0;
  logic [7:0] internal_bus = 8'h00;
  logic       init_done, ltim, single_mode, ocw2_valid, read_isr_sel;
  logic       special_mask, poll_pulse, seq_error;
  logic [4:0] vector_base, icw4_cfg;
  logic [7:0] cascade_cfg, imr;
  logic [2:0] ocw2_cmd, ocw2_level;

  int vecs = 0;
  int miss = 0;

`ifdef PIC_POLL_EN
  localparam logic POLL_EXP = 1'b1;
`else
  localparam logic POLL_EXP = 1'b0;
`endif

  icw_ocw_sequencer dut (
    .clk(clk), .reset(reset), .write_bar(write_bar),
    .chip_select_bar(chip_select_bar), .A0(A0), .internal_bus(internal_bus),
    .init_done(init_done), .vector_base(vector_base), .ltim(ltim),
    .single_mode(single_mode), .cascade_cfg(cascade_cfg), .icw4_cfg(icw4_cfg),
    .imr(imr), .ocw2_valid(ocw2_valid), .ocw2_cmd(ocw2_cmd),
    .ocw2_level(ocw2_level), .read_isr_sel(read_isr_sel),
    .special_mask(special_mask), .poll_pulse(poll_pulse), .seq_error(seq_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vecs++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One-clk write; returns one cycle after the commit edge so registered
  // results and pulses are visible. cs_end ends the write by raising CS.
  task automatic wr(input logic a0, input logic [7:0] d, input logic cs_end = 1'b0);
    @(posedge clk); #1;
    write_bar = 1'b0; chip_select_bar = 1'b0; A0 = a0; internal_bus = d;
    @(posedge clk); #1;
    if (cs_end) chip_select_bar = 1'b1;
    else begin write_bar = 1'b1; chip_select_bar = 1'b1; end
    internal_bus = 8'hEE; A0 = ~a0;
    @(posedge clk); #1;
    write_bar = 1'b1; chip_select_bar = 1'b1;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (2) step();
    reset = 1'b0;
    step();
    chk("rst_init_done", init_done, 0);
    chk("rst_imr", imr, 8'h00);
    chk("rst_pulses", {ocw2_valid, poll_pulse, seq_error}, 0);

    // Non-ICW1 write while uninitialized is dropped silently.
    wr(1'b1, 8'hFF);
    chk("uninit_vb", vector_base, 0);
    chk("uninit_err", seq_error, 0);

    // Single, with ICW4.
    wr(1'b0, 8'h13);
    chk("s1_done0", init_done, 0);
    chk("s1_sngl", single_mode, 1);
    wr(1'b1, 8'h40);
    chk("s1_vb", vector_base, 5'h08);
    chk("s1_done_icw2", init_done, 0);
    wr(1'b1, 8'h01);
    chk("s1_done", init_done, 1);
    chk("s1_icw4", icw4_cfg, 5'h01);
    chk("s1_casc", cascade_cfg, 8'h00);

    // Cascaded, no ICW4, with an illegal write during ICW2.
    wr(1'b0, 8'h10);
    chk("s2_icw4_clr", icw4_cfg, 0);
    chk("s2_done0", init_done, 0);
    wr(1'b0, 8'h20);
    chk("s2_err", seq_error, 1);
    step();
    chk("s2_err_1clk", seq_error, 0);
    wr(1'b1, 8'h20);
    chk("s2_vb", vector_base, 5'h04);
    chk("s2_done_icw2", init_done, 0);
    wr(1'b1, 8'h04);
    chk("s2_casc", cascade_cfg, 8'h04);
    chk("s2_done", init_done, 1);
    chk("s2_icw4", icw4_cfg, 0);

    // OCW1 / OCW2.
    wr(1'b1, 8'hA5);
    chk("ocw1_imr", imr, 8'hA5);
    wr(1'b0, 8'h63);
    chk("ocw2_vld", ocw2_valid, 1);
    chk("ocw2_cmd", ocw2_cmd, 3'b011);
    chk("ocw2_lvl", ocw2_level, 3'd3);
    step();
    chk("ocw2_vld_1clk", ocw2_valid, 0);
    chk("ocw2_cmd_hold", ocw2_cmd, 3'b011);

    // OCW3.
    wr(1'b0, 8'h0B);
    chk("ocw3_ris", read_isr_sel, 1);
    chk("ocw3_smm0", special_mask, 0);
    chk("ocw3_nopoll", poll_pulse, 0);
    wr(1'b0, 8'h6C);
    chk("ocw3_smm", special_mask, 1);
    chk("ocw3_poll", poll_pulse, POLL_EXP);
    chk("ocw3_ris_keep", read_isr_sel, 1);
    step();
    chk("ocw3_poll_1clk", poll_pulse, 0);

    // Chip-select rise ends the write while write_bar is still low.
    wr(1'b1, 8'h3C, 1'b1);
    chk("cs_end_imr", imr, 8'h3C);

    // ICW1 in READY clears OCW state; re-issue mid-sequence restarts at ICW2.
    wr(1'b0, 8'h1B);
    chk("re_imr", imr, 0);
    chk("re_ris", read_isr_sel, 0);
    chk("re_smm", special_mask, 0);
    chk("re_ltim", ltim, 1);
    chk("re_done", init_done, 0);
    wr(1'b1, 8'hF8);
    chk("re_vb", vector_base, 5'h1F);
    wr(1'b0, 8'h12);
    chk("re2_ltim", ltim, 0);
    wr(1'b1, 8'h88);
    chk("re2_vb", vector_base, 5'h11);
    chk("re2_done", init_done, 1);

    // Async reset in the middle of a write: no commit afterwards.
    @(posedge clk); #1;
    write_bar = 1'b0; chip_select_bar = 1'b0; A0 = 1'b1; internal_bus = 8'h77;
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    chk("ar_done", init_done, 0);
    chk("ar_vb", vector_base, 0);
    chk("ar_ltim", ltim, 0);
    write_bar = 1'b1; chip_select_bar = 1'b1;
    step();
    reset = 1'b0;
    repeat (3) step();
    chk("ar_imr", imr, 0);
    chk("ar_pulses", {ocw2_valid, poll_pulse, seq_error}, 0);
    chk("ar_nocommit", {init_done, vector_base}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
